debounce_bank: RTL and testbench

//  Multi-channel successor to the single-button debouncer. Debounces NUM_CH raw board inputs
//  (push-buttons, DIP switches, async strobes) against one shared millisecond timebase.

---
 rtl/ice_pkg.sv | 30 +++
 rtl/debounce_ch.sv | 123 ++++++++++++
 rtl/debounce_bank.sv | 85 ++++++++
 tb/tb_debounce_bank.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ice_pkg.sv
// ---------------------------------------------------------------------------
// ice_pkg
// Shared constants and helpers for the ICE board-level logic.
//   SYS_CLK_HZ     : system clock frequency in Hz
//   CYCLES_PER_MS  : system clock cycles in one millisecond (default timebase)
//   ch_state_e     : per-channel debounce state (input agrees / disagrees)
//   cnt_width()    : bits needed to hold values 0..max_val, never less than 1
// ---------------------------------------------------------------------------
package ice_pkg;

    localparam int SYS_CLK_HZ    = 20_000_000;
    localparam int CYCLES_PER_MS = SYS_CLK_HZ / 1000;

    typedef enum logic {
        CH_STABLE  = 1'b0,
        CH_PENDING = 1'b1
    } ch_state_e;

    // Equivalent to $clog2(max_val + 1) with a floor of one bit, so counters
    // whose limit is 0 or 1 still get a legal one-bit register.
    function automatic int cnt_width(input int max_val);
        int w;
        w = 1;
        while ((w < 31) && ((1 << w) <= max_val)) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/debounce_ch.sv
// ---------------------------------------------------------------------------
// debounce_ch
// One debounce channel: two-flop synchroniser, debounce counter, long-press
// hold counter and registered edge pulses. Timing is measured in ms ticks
// supplied by the parent.
// Ports:
//   clk         in   system clock
//   reset       in   synchronous active-high reset
//   ms_tick     in   one-cycle pulse per millisecond (shared timebase)
//   din         in   raw asynchronous input (before optional inversion)
//   db_out      out  debounced level
//   rise        out  one-cycle pulse in the first cycle db_out reads 1
//   fall        out  one-cycle pulse in the first cycle db_out reads 0
//   long_press  out  one-cycle pulse once db_out has been high LONG_MS ticks
// ---------------------------------------------------------------------------
module debounce_ch
    import ice_pkg::*;
#(
    parameter int   DB_MS   = 5,
    parameter int   LONG_MS = 1000,
    parameter logic INVERT  = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic ms_tick,
    input  logic din,
    output logic db_out,
    output logic rise,
    output logic fall,
    output logic long_press
);

    localparam int DB_W   = cnt_width(DB_MS);
    localparam int HOLD_W = cnt_width(LONG_MS);

    localparam logic [DB_W-1:0]   DB_LAST  = DB_W'(DB_MS - 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(LONG_MS);
    localparam logic              LONG_EN  = (LONG_MS != 0);

    logic              sync1_q, sync1_d;
    logic              sync_q, sync_d;
    logic [DB_W-1:0]   db_cnt_q, db_cnt_d;
    logic              db_out_q, db_out_d;
    logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
    logic              rise_q, rise_d;
    logic              fall_q, fall_d;
    logic              long_q, long_d;
    ch_state_e         state;

    always_comb begin
        sync1_d    = din ^ INVERT;
        sync_d     = sync1_q;
        db_out_d   = db_out_q;
        db_cnt_d   = '0;
        hold_cnt_d = '0;
        long_d     = 1'b0;

        state = (sync_q != db_out_q) ? CH_PENDING : CH_STABLE;

        // Any cycle in which the synchronised input agrees with the output
        // clears the count, so a bounce restarts the full DB_MS window even
        // if a tick lands in that same cycle.
        unique case (state)
            CH_STABLE: begin
                db_cnt_d = '0;
            end
            CH_PENDING: begin
                db_cnt_d = db_cnt_q;
                if (ms_tick) begin
                    if (db_cnt_q == DB_LAST) begin
                        db_out_d = ~db_out_q;
                        db_cnt_d = '0;
                    end else begin
                        db_cnt_d = db_cnt_q + DB_W'(1);
                    end
                end
            end
        endcase

        // Saturating at HOLD_MAX means the equality below is seen only on
        // the one tick that reaches the limit: one pulse per press.
        if (db_out_q) begin
            hold_cnt_d = hold_cnt_q;
            if (ms_tick && (hold_cnt_q != HOLD_MAX)) begin
                hold_cnt_d = hold_cnt_q + HOLD_W'(1);
                long_d     = LONG_EN && (hold_cnt_d == HOLD_MAX);
            end
        end

        // Edge pulses are registered alongside db_out so they appear in the
        // same cycle the new level first shows on the output.
        rise_d = db_out_d & ~db_out_q;
        fall_d = ~db_out_d & db_out_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q    <= 1'b0;
            sync_q     <= 1'b0;
            db_cnt_q   <= '0;
            db_out_q   <= 1'b0;
            hold_cnt_q <= '0;
            rise_q     <= 1'b0;
            fall_q     <= 1'b0;
            long_q     <= 1'b0;
        end else begin
            sync1_q    <= sync1_d;
            sync_q     <= sync_d;
            db_cnt_q   <= db_cnt_d;
            db_out_q   <= db_out_d;
            hold_cnt_q <= hold_cnt_d;
            rise_q     <= rise_d;
            fall_q     <= fall_d;
            long_q     <= long_d;
        end
    end

    assign db_out     = db_out_q;
    assign rise       = rise_q;
    assign fall       = fall_q;
    assign long_press = long_q;

endmodule

// File: rtl/debounce_bank.sv
// ---------------------------------------------------------------------------
// debounce_bank
// Debounces NUM_CH raw board inputs against one shared millisecond timebase
// and reports per-channel level, rise/fall pulses and a long-press pulse.
// Ports:
//   clk         in   system clock
//   reset       in   synchronous active-high reset
//   db_in       in   [NUM_CH] raw asynchronous inputs
//   db_out      out  [NUM_CH] debounced levels (after active-low inversion)
//   rise        out  [NUM_CH] one-cycle pulse on db_out 0->1
//   fall        out  [NUM_CH] one-cycle pulse on db_out 1->0
//   long_press  out  [NUM_CH] one-cycle pulse after LONG_MS ms held high
//   ms_tick     out  one-cycle pulse every TICK_DIV cycles, for other blocks
// ---------------------------------------------------------------------------
module debounce_bank
    import ice_pkg::*;
#(
    parameter int          NUM_CH      = 4,
    parameter int          TICK_DIV    = CYCLES_PER_MS,
    parameter int          DB_MS       = 5,
    parameter int          LONG_MS     = 1000,
    parameter logic [31:0] INVERT_MASK = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NUM_CH-1:0] db_in,
    output logic [NUM_CH-1:0] db_out,
    output logic [NUM_CH-1:0] rise,
    output logic [NUM_CH-1:0] fall,
    output logic [NUM_CH-1:0] long_press,
    output logic              ms_tick
);

    localparam int               PRE_W    = cnt_width(TICK_DIV - 1);
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);

    if (TICK_DIV < 2) begin : g_bad_tick_div
        $error("debounce_bank: TICK_DIV must be at least 2");
    end
    if (DB_MS < 1) begin : g_bad_db_ms
        $error("debounce_bank: DB_MS must be at least 1");
    end
    if ((NUM_CH < 1) || (NUM_CH > 32)) begin : g_bad_num_ch
        $error("debounce_bank: NUM_CH must be within 1..32");
    end

    logic [PRE_W-1:0] pre_q, pre_d;

    // Free-running prescaler; it starts at 0 out of reset so the first tick
    // arrives TICK_DIV cycles later.
    always_comb begin
        pre_d = pre_q + PRE_W'(1);
        if (pre_q == PRE_LAST) begin
            pre_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pre_q <= '0;
        end else begin
            pre_q <= pre_d;
        end
    end

    assign ms_tick = (pre_q == PRE_LAST);

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        debounce_ch #(
            .DB_MS   (DB_MS),
            .LONG_MS (LONG_MS),
            .INVERT  (INVERT_MASK[i])
        ) u_ch (
            .clk        (clk),
            .reset      (reset),
            .ms_tick    (ms_tick),
            .din        (db_in[i]),
            .db_out     (db_out[i]),
            .rise       (rise[i]),
            .fall       (fall[i]),
            .long_press (long_press[i])
        );
    end

endmodule

// File: tb/tb_debounce_bank.sv
// ---------------------------------------------------------------------------
// tb_debounce_bank
// Drives debounce_bank with directed scenarios plus random input activity
// and compares every output on every cycle against a timestamp-based model.
// ---------------------------------------------------------------------------
module tb_debounce_bank;

    localparam int         NUM_CH   = 4;
    localparam int         TICK_DIV = 10;
    localparam int         DB_MS    = 4;
    localparam int         LONG_MS  = 8;
    localparam logic [3:0] INV      = 4'b0010;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] db_in = 4'b0010;
    logic [3:0] db_out, rise, fall, long_press;
    logic       ms_tick;

    int total = 0;
    int bad = 0;

    debounce_bank #(
        .NUM_CH      (NUM_CH),
        .TICK_DIV    (TICK_DIV),
        .DB_MS       (DB_MS),
        .LONG_MS     (LONG_MS),
        .INVERT_MASK ({28'd0, INV})
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .db_in      (db_in),
        .db_out     (db_out),
        .rise       (rise),
        .fall       (fall),
        .long_press (long_press),
        .ms_tick    (ms_tick)
    );

    always #5 clk = ~clk;

    // The model works in absolute cycle numbers counted from the last reset
    // edge: ticks fall on cycles where cyc % TICK_DIV == TICK_DIV-1, the
    // synchronised input is the pin value from two cycles earlier, and a
    // level flips once DB_MS ticks have landed inside an unbroken
    // disagreement window.
    int         cyc;
    logic [3:0] s_hist[$];
    int         run_start[4];
    int         press_start[4];
    logic [3:0] exp_out, exp_rise, exp_fall, exp_long;
    logic       exp_tick;
    int         rise_seen[4];
    int         fall_seen[4];
    int         long_seen[4];

    function automatic int ticks_in(input int a, input int b);
        return (b + 1) / TICK_DIV - a / TICK_DIV;
    endfunction

    function automatic logic is_tick(input int c);
        return (c % TICK_DIV) == (TICK_DIV - 1);
    endfunction

    task automatic modelReset();
        cyc = 0;
        s_hist.delete();
        for (int i = 0; i < 4; i++) begin
            run_start[i]   = -1;
            press_start[i] = -1;
        end
        exp_out  = '0;
        exp_rise = '0;
        exp_fall = '0;
        exp_long = '0;
        exp_tick = 1'b0;
    endtask

    task automatic modelAdvance(input logic [3:0] din_v);
        logic [3:0] s, sync_v, nxt, lp;
        s = din_v ^ INV;
        s_hist.push_back(s);
        sync_v = (cyc >= 2) ? s_hist[cyc-2] : 4'b0000;
        nxt = exp_out;
        lp  = '0;
        for (int i = 0; i < 4; i++) begin
            if (sync_v[i] != exp_out[i]) begin
                if (run_start[i] < 0) run_start[i] = cyc;
                if (is_tick(cyc) && ticks_in(run_start[i], cyc) == DB_MS) begin
                    nxt[i] = ~exp_out[i];
                    run_start[i] = -1;
                end
            end else begin
                run_start[i] = -1;
            end
            if (exp_out[i] && is_tick(cyc) && ticks_in(press_start[i], cyc) == LONG_MS)
                lp[i] = 1'b1;
            if (nxt[i] && !exp_out[i]) press_start[i] = cyc + 1;
            if (!nxt[i]) press_start[i] = -1;
        end
        exp_rise = nxt & ~exp_out;
        exp_fall = ~nxt & exp_out;
        exp_long = lp;
        exp_out  = nxt;
        cyc      = cyc + 1;
        exp_tick = is_tick(cyc);
    endtask

    task automatic checkOutput();
        total++;
        assert (db_out === exp_out) else begin
            bad++;
            $error("[TB] FAIL db_out cyc=%0d observed=%b expected=%b", cyc, db_out, exp_out);
        end
        total++;
        assert (rise === exp_rise) else begin
            bad++;
            $error("[TB] FAIL rise cyc=%0d observed=%b expected=%b", cyc, rise, exp_rise);
        end
        total++;
        assert (fall === exp_fall) else begin
            bad++;
            $error("[TB] FAIL fall cyc=%0d observed=%b expected=%b", cyc, fall, exp_fall);
        end
        total++;
        assert (long_press === exp_long) else begin
            bad++;
            $error("[TB] FAIL long_press cyc=%0d observed=%b expected=%b", cyc, long_press, exp_long);
        end
        total++;
        assert (ms_tick === exp_tick) else begin
            bad++;
            $error("[TB] FAIL ms_tick cyc=%0d observed=%b expected=%b", cyc, ms_tick, exp_tick);
        end
        for (int i = 0; i < 4; i++) begin
            if (rise[i] === 1'b1) rise_seen[i]++;
            if (fall[i] === 1'b1) fall_seen[i]++;
            if (long_press[i] === 1'b1) long_seen[i]++;
        end
    endtask

    task automatic checkCount(input string tag, input int observed, input int expected);
        total++;
        assert (observed == expected) else begin
            bad++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    task automatic clearCounts();
        for (int i = 0; i < 4; i++) begin
            rise_seen[i] = 0;
            fall_seen[i] = 0;
            long_seen[i] = 0;
        end
    endtask

    task automatic applyStimulus(input logic [3:0] din_v, input logic rst_v, input int ncyc);
        for (int k = 0; k < ncyc; k++) begin
            @(negedge clk);
            checkOutput();
            reset = rst_v;
            db_in = din_v;
            if (rst_v) modelReset();
            else modelAdvance(din_v);
        end
    endtask

    initial begin
        logic [3:0] din;
        logic       lvl;
        modelReset();
        clearCounts();
        din = 4'b0010;

        // Reset, then idle with channel 1 (active-low) released.
        applyStimulus(din, 1'b1, 5);
        applyStimulus(din, 1'b0, 100);
        checkCount("idle_rises", rise_seen[0] + rise_seen[1] + rise_seen[2] + rise_seen[3], 0);

        // Clean press on channel 0.
        clearCounts();
        din[0] = 1'b1;
        applyStimulus(din, 1'b0, 50);
        checkCount("clean_rise0", rise_seen[0], 1);
        checkCount("clean_fall0", fall_seen[0], 0);
        din[0] = 1'b0;
        applyStimulus(din, 1'b0, 50);

        // Bouncing channel 0 settling high.
        clearCounts();
        lvl = 1'b1;
        for (int k = 0; k < 4; k++) begin
            din[0] = lvl;
            applyStimulus(din, 1'b0, int'($urandom_range(6, 24)));
            lvl = ~lvl;
        end
        din[0] = 1'b1;
        applyStimulus(din, 1'b0, 60);
        checkCount("bounce_rise0", rise_seen[0], 1);

        // Long press on active-low channel 1, then release.
        clearCounts();
        din[1] = 1'b0;
        applyStimulus(din, 1'b0, 140 + int'($urandom_range(0, 40)));
        din[1] = 1'b1;
        applyStimulus(din, 1'b0, 60);
        checkCount("press_rise1", rise_seen[1], 1);
        checkCount("press_long1", long_seen[1], 1);
        checkCount("press_fall1", fall_seen[1], 1);

        // Channels 2 and 3 change together.
        clearCounts();
        din[3:2] = 2'b11;
        applyStimulus(din, 1'b0, 60);
        checkCount("pair_rise2", rise_seen[2], 1);
        checkCount("pair_rise3", rise_seen[3], 1);
        din[3:2] = 2'b00;
        applyStimulus(din, 1'b0, 60);

        // Reset while channel 2 is pending, then full timing restarts.
        din[2] = 1'b1;
        applyStimulus(din, 1'b0, 25);
        applyStimulus(din, 1'b1, 3);
        applyStimulus(din, 1'b0, 60);

        // Reset while channel 1 is being held, then a fresh hold.
        clearCounts();
        din[1] = 1'b0;
        applyStimulus(din, 1'b0, 70);
        applyStimulus(din, 1'b1, 3);
        applyStimulus(din, 1'b0, 140);
        checkCount("rehold_long1", long_seen[1], 1);
        din = 4'b0010;
        applyStimulus(din, 1'b0, 60);

        // Random activity on all channels.
        for (int k = 0; k < 40; k++) begin
            din = 4'($urandom);
            applyStimulus(din, 1'b0, int'($urandom_range(1, 45)));
        end
        applyStimulus(din, 1'b0, 60);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
